// File: rtl/exec_unit.sv
// exec_unit: ALU execute stage with iterative MUL/DIV and write-back pulse.
// Ports: clk/rst, issue (valid/ready, op, rd_in, a, b), flush, wb_*, flags.
module exec_unit #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [2:0]        op,
  input  logic [2:0]        rd_in,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              flush,
  output logic              wb_we,
  output logic [2:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_z,
  output logic              flag_c
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_DIV = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV
  } state_t;

  state_t state, state_nx;

  logic [2:0]          cnt;
  logic [2:0]          rd_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [DATA_W-1:0]   rem;
  logic [2*DATA_W-1:0] prod;

  logic accept;
  logic last;
  logic long_op;

  assign issue_ready = (state == IDLE);
  // flush in IDLE suppresses a same-cycle issue
  assign accept  = issue_valid && issue_ready && !flush;
  assign last    = (cnt == 3'd7);
  assign long_op = (op == OP_MUL) || (op == OP_DIV);

  // single-cycle ALU
  logic [DATA_W:0]     sum_w;
  logic [2*DATA_W-1:0] shl_w;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;

  assign sum_w = {1'b0, a} + {1'b0, b};
  assign shl_w = {{DATA_W{1'b0}}, a} << b[2:0];

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    unique case (1'b1)
      (op == OP_ADD): begin
        alu_res = sum_w[DATA_W-1:0];
        alu_c   = sum_w[DATA_W];
      end
      (op == OP_SUB): begin
        alu_res = a - b;
        alu_c   = (a < b);
      end
      (op == OP_AND): alu_res = a & b;
      (op == OP_OR):  alu_res = a | b;
      (op == OP_XOR): alu_res = a ^ b;
      (op == OP_SHL): begin
        // bit DATA_W holds the last bit shifted out; zero for shift 0
        alu_res = shl_w[DATA_W-1:0];
        alu_c   = shl_w[DATA_W];
      end
      default: ;
    endcase
  end

  // shift-add multiply step: add a << cnt when b bit cnt is set
  logic [2*DATA_W-1:0] mul_add;
  logic [2*DATA_W-1:0] prod_nx;

  assign mul_add = b_q[cnt] ? ({{DATA_W{1'b0}}, a_q} << cnt) : '0;
  assign prod_nx = prod + mul_add;

  // restoring divide step: dividend shifts out of a_q, quotient shifts in
  logic [DATA_W+1:0]   div_diff;
  logic                qbit;
  logic [DATA_W-1:0]   rem_nx;
  logic [DATA_W-1:0]   quot_nx;

  assign div_diff = {1'b0, rem, a_q[DATA_W-1]} - {2'b00, b_q};
  assign qbit     = !div_diff[DATA_W+1];
  assign rem_nx   = qbit ? div_diff[DATA_W-1:0]
                         : {rem[DATA_W-2:0], a_q[DATA_W-1]};
  assign quot_nx  = {a_q[DATA_W-2:0], qbit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept && op == OP_MUL) state_nx = MUL;
        if (accept && op == OP_DIV) state_nx = DIV;
      end
      MUL, DIV: begin
        if (flush || last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem     <= '0;
      prod    <= '0;
      wb_we   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
    end else begin
      wb_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_q  <= a;
            b_q  <= b;
            rd_q <= rd_in;
            cnt  <= '0;
            rem  <= '0;
            prod <= '0;
            if (!long_op) begin
              wb_we   <= 1'b1;
              wb_rd   <= rd_in;
              wb_data <= alu_res;
              flag_z  <= (alu_res == '0);
              flag_c  <= alu_c;
            end
          end
        end
        MUL: begin
          if (flush) begin
            cnt <= '0;
          end else begin
            prod <= prod_nx;
            cnt  <= cnt + 3'd1;
            if (last) begin
              wb_we   <= 1'b1;
              wb_rd   <= rd_q;
              wb_data <= prod_nx[DATA_W-1:0];
              flag_z  <= (prod_nx[DATA_W-1:0] == '0);
              flag_c  <= |prod_nx[2*DATA_W-1:DATA_W];
            end
          end
        end
        DIV: begin
          if (flush) begin
            cnt <= '0;
          end else begin
            // b == 0 never borrows, so the quotient fills with ones
            a_q <= quot_nx;
            rem <= rem_nx;
            cnt <= cnt + 3'd1;
            if (last) begin
              wb_we   <= 1'b1;
              wb_rd   <= rd_q;
              wb_data <= quot_nx;
              flag_z  <= (quot_nx == '0);
              flag_c  <= (b_q == '0);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/exec_unit.md
# exec_unit

Execute stage of the 8-bit processor, directly downstream of the register file. It takes the two source operands read from the register file, performs one ALU operation, and produces the write-back triple (`wb_we`, `wb_rd`, `wb_data`) that drives the register file write port. Single-cycle ops complete in one clock. MUL and DIV are iterative 8-cycle ops; an issue handshake stalls the front end while they run.

## Interface
- `DATA_W`, default 8: operand/result width. The design is verified at 8 only.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `issue_valid`  in  1: operation presented this cycle.
- `issue_ready`  out  1: unit can accept; equals (state == IDLE).
- `op`  in  3: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 MUL, 111 DIV.
- `rd_in`  in  3: destination register index.
- `a`, `b`  in  DATA_W each: operands (rs1_out, rs2_out of the register file).
- `flush`  in  1: abort any in-flight MUL/DIV.
- `wb_we`  out  1: one-cycle write-enable pulse to the register file.
- `wb_rd`  out  3: destination index for the pulse.
- `wb_data`  out  DATA_W: result.
- `flag_z`, `flag_c`  out  1 each: zero and carry of the last written result.

## Operation
- Accept: when `issue_valid && issue_ready` at a rising edge, the unit captures `op`, `rd_in`, `a` and `b`. Later changes to the register file do not affect the operation.
- States:
  - IDLE: on accept of ops 000–101, compute the result and write back; stay in IDLE. On accept of MUL go to MUL; on accept of DIV go to DIV. Load the 3-bit iteration counter with 0.
  - MUL: shift-add multiply. One partial-product step per edge. After the 8th step, write back and return to IDLE.
  - DIV: restoring division. One quotient bit per edge, MSB first. After the 8th step, write back and return to IDLE.
- Results (mod 2^8) and carry:
  - ADD: a+b; C = bit 8 of the sum.
  - SUB: a−b; C = borrow (a<b, unsigned).
  - AND/OR/XOR: C = 0.
  - SHL: a << b[2:0]; C = last bit shifted out; C = 0 when b[2:0]=0.
  - MUL: low byte of a*b; C = 1 iff the high byte is nonzero.
  - DIV: unsigned quotient a/b, remainder discarded; C = 0.
  - DIV with b=0: quotient 0xFF, C = 1, still 8 cycles.
- Z = (wb_data == 0). Flags update only on a `wb_we` pulse and otherwise hold.
- `wb_we` is registered and high for exactly one cycle per completed op. `wb_rd` and `wb_data` hold their last values when `wb_we` = 0.
- Flush:
  - In MUL/DIV: return to IDLE on the next edge with no write-back; flags unchanged.
  - In IDLE: an issue in the same cycle is ignored; no accept occurs.
- `issue_valid` while busy is ignored. The issuer holds the op until `issue_ready`.
- No hazard detection or forwarding inside the unit; the issuer is responsible for it.

## Timing
- Reset values:
  - State IDLE, so `issue_ready` = 1.
  - `wb_we` = 0, `wb_rd` = 0, `wb_data` = 0x00.
  - `flag_z` = 0, `flag_c` = 0.
  - Iteration counter = 0.
- Reset mid-MUL/DIV aborts the op: no write-back, outputs return to their reset values immediately.
- Single-cycle ops: accepted at edge k, so `wb_we` = 1 during cycle k→k+1. A new op can be accepted at edge k+1, giving back-to-back throughput of 1 op/cycle.
- MUL/DIV:
  - Accepted at edge k; `issue_ready` = 0 from after edge k until edge k+8.
  - Steps occur at edges k+1..k+8.
  - After edge k+8, `wb_we` = 1 and `issue_ready` = 1 in the same cycle.
  - The next accept is possible at edge k+9. Latency is 8 cycles after accept.
- Flush at edge j while busy: `issue_ready` = 1 after edge j, and the counter is cleared.
- Flush and final step at the same edge: flush wins, no write-back.
- Counter wraps from 7 to 0. The terminal step is the edge where the counter = 7.

## Test plan
- Reset, then ADD a=0xF0, b=0x20, rd=3 → next cycle `wb_we`=1, `wb_rd`=3, `wb_data`=0x10, C=1, Z=0.
- Back-to-back: SUB 0x05−0x05, then XOR 0xAA^0x55, then SHL 0x81<<1 on consecutive edges → three consecutive pulses with:
  - 0x00 (Z=1, C=0)
  - 0xFF (Z=0, C=0)
  - 0x02 (C=1)
- MUL a=0x10, b=0x11, rd=5 → `issue_ready` low for 8 cycles; pulse after edge k+8 with 0x10, C=1. Operand registers in the source are changed mid-op and the result is unaffected.
- DIV 0xC8/0x07 → 0x1C, C=0. DIV 0x42/0x00 → 0xFF, C=1. Both take 8 cycles.
- Flush at edge k+4 of a MUL → no pulse, flags unchanged, `issue_ready`=1 after edge k+4. A following ADD completes normally.
- Async `rst` asserted between edges during a DIV → outputs immediately at their reset values, state IDLE, no write-back after release.
